// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed from the latched operands on the edge where the busy counter expires.
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | no op in flight; accepts MULT/DIV issue and MTHI/MTLO writes
    // RUN   | op in flight; cnt counts down to the result-write edge
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prod_s, prod_u, ext_as, ext_bs;
    logic               div_signed, neg_q, neg_r;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        ext_as = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_bs = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_s = ext_as * ext_bs;
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        // Signed division runs on magnitudes; most-negative / -1 wraps back to a naturally.
        div_signed = (op_q == 2'd2);
        a_mag  = (div_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag  = (div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        neg_q  = div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r  = div_signed && a_q[WIDTH-1];
        quo    = neg_q ? -q_mag : q_mag;
        rem    = neg_r ? -r_mag : r_mag;

        res_hi = '0;
        res_lo = '0;
        case (op_q)
            2'd0:    {res_hi, res_lo} = prod_s;
            2'd1:    {res_hi, res_lo} = prod_u;
            default: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = a;
                            b_d     = b;
                            op_d    = op[1:0];
                            cnt_d   = op[1] ? DIV_CNT : MUL_CNT;
                            state_d = RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of ops with hand-computed HI/LO, plus cancel/reset sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi, m_lo;

    md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts busy cycles from the current negedge until busy drops (bounded).
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic watch_no_done(input int cycles, input string name);
        logic seen = 1'b0;
        repeat (cycles) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check(name, 64'(seen), 64'd0);
    endtask

    // Called at a negedge; drives the op for one edge and checks the result.
    task automatic run_vec(input int i);
        int n;
        op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (vecs[i].lat == 0) begin
            check({vecs[i].name, "_busy"}, 64'(busy), 64'd0);
            check({vecs[i].name, "_done"}, 64'(done), 64'd0);
        end else begin
            wait_busy(n);
            check({vecs[i].name, "_lat"}, 64'(n), 64'(vecs[i].lat));
            check({vecs[i].name, "_done"}, 64'(done), 64'd1);
        end
        check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
        check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
        @(negedge clk);
        check({vecs[i].name, "_done_off"}, 64'(done), 64'd0);
        m_hi = vecs[i].hi;
        m_lo = vecs[i].lo;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        vecs[0]  = '{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{"mult_mix",   3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[3]  = '{"multu_2p32", 3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[4]  = '{"div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{"divu_zero",  3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10};
        vecs[6]  = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{"divu_plain", 3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[8]  = '{"div_negb",   3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{"div_zero",   3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 10};
        vecs[10] = '{"mthi",       3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 0};
        vecs[11] = '{"mtlo",       3'd5, 32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 0};
        vecs[12] = '{"nop6",       3'd6, 32'h00000001, 32'd1,        32'h12345678, 32'hCAFEF00D, 0};

        #1;
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) run_vec(i);

        // Second start in busy cycle 2 must be ignored.
        op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 3'd2; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_busy(n);
        check("ign_lat",  64'(n + 2), 64'd5);
        check("ign_done", 64'(done),  64'd1);
        check("ign_hi",   64'(hi),    64'hFFFFFFFE);
        check("ign_lo",   64'(lo),    64'h00000001);
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
        @(negedge clk);

        // Cancel in busy cycle 3.
        op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cx3_busy", 64'(busy), 64'd0);
        watch_no_done(8, "cx3_nodone");
        check("cx3_hi", 64'(hi), 64'(m_hi));
        check("cx3_lo", 64'(lo), 64'(m_lo));

        // Cancel on the cnt=1 cycle (busy cycle 5).
        op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cx5_busy", 64'(busy), 64'd0);
        watch_no_done(8, "cx5_nodone");
        check("cx5_hi", 64'(hi), 64'(m_hi));
        check("cx5_lo", 64'(lo), 64'(m_lo));

        // Cancel in IDLE suppresses MTHI and MULT issue.
        op = 3'd4; a = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cxi_busy", 64'(busy), 64'd0);
        check("cxi_hi",   64'(hi),   64'(m_hi));

        // Async reset pulse between edges in DIV busy cycle 4.
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_hi",   64'(hi),   64'd0);
        check("ar_lo",   64'(lo),   64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_done", 64'(done), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        watch_no_done(20, "ar_nodone");
        check("ar_hi_hold", 64'(hi), 64'd0);
        check("ar_lo_hold", 64'(lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand and HI/LO register width.
REQ-002 SHALL provide parameter MUL_LAT, default 5: busy cycles for MULT/MULTU; legal range 1..255.
REQ-003 SHALL provide parameter DIV_LAT, default 10: busy cycles for DIV/DIVU; legal range 1..255.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request to issue op in this cycle.
REQ-007 SHALL have port op  input  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-008 SHALL have port a  input  WIDTH: rs operand.
REQ-009 SHALL have port b  input  WIDTH: rt operand.
REQ-010 SHALL have port cancel  input  1: abort the in-flight op (exception flush).
REQ-011 SHALL have port busy  output  1: multi-cycle op in flight.
REQ-012 SHALL have port done  output  1: one-cycle pulse, the result was written to HI/LO.
REQ-013 SHALL have port hi  output  WIDTH: HI register.
REQ-014 SHALL have port lo  output  WIDTH: LO register.

Function
REQ-015 SHALL have two states: IDLE (busy=0) and RUN (busy=1), plus a down-counter cnt of 8 bits.
REQ-016 IDLE, start=1, cancel=0, op in 0-3: SHALL latch a, b and op, load cnt with MUL_LAT (op 0-1) or DIV_LAT (op 2-3), and enter RUN at the next edge.
REQ-017 IDLE, start=1, cancel=0, op 4 (MTHI) or 5 (MTLO): SHALL write a to hi or lo at the next edge, stay IDLE, and leave done=0.
REQ-018 start with op 6-7: SHALL have no effect.
REQ-019 start=1 while busy=1: SHALL be ignored, with no change to the latched operands or cnt.
REQ-020 RUN: SHALL decrement cnt every cycle; the edge at which cnt goes 1->0 SHALL write hi/lo, enter IDLE and assert done for exactly the following cycle.
REQ-021 Latency: op issued at edge t SHALL give busy=1 for exactly LAT cycles and hi/lo/done updated at edge t+LAT.
REQ-022 MULT: {hi,lo} SHALL equal the 2*WIDTH signed product of a and b.
REQ-023 MULTU: {hi,lo} SHALL equal the 2*WIDTH unsigned product of a and b.
REQ-024 DIVU: lo SHALL equal a/b and hi SHALL equal a%b, unsigned.
REQ-025 DIV: the quotient SHALL truncate toward zero, and the remainder SHALL take the sign of a.
REQ-026 Divide by zero (b=0, DIV or DIVU): SHALL set lo=all ones and hi=a, with done still pulsing.
REQ-027 DIV with a=most-negative and b=-1: SHALL set lo=a and hi=0, with no other flag.
REQ-028 cancel=1 in RUN: SHALL return to IDLE at the next edge with cnt=0, leave hi/lo unchanged, and keep done=0.
REQ-029 cancel=1 in IDLE: SHALL suppress any start in the same cycle, including MTHI/MTLO.
REQ-030 cancel=1 on the cycle where cnt=1: cancel SHALL win, with no hi/lo write and no done.
REQ-031 hi/lo SHALL change only per REQ-017 and REQ-020, and SHALL otherwise hold their value indefinitely.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for clk, force hi=0, lo=0, busy=0, done=0, cnt=0 and state IDLE.
REQ-033 reset asserted mid-RUN SHALL discard the op, and no done SHALL follow after release.
REQ-034 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a second start issued in cycle 2 of busy is ignored, and busy falls after exactly 5 cycles.
REQ-038 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy stays 0, done stays 0.
REQ-039 MULT start, then cancel in busy cycle 3 -> busy=0 next cycle, hi/lo keep their prior values, no done; cancel on the cnt=1 cycle gives the same result.
REQ-040 Reset pulse between edges during DIV busy cycle 4 -> outputs go to 0 before the next edge, and no done appears in the 20 cycles after release.
